// File: rtl/sigmoid_simd_collector.sv
// sigmoid_simd_collector
// Consumer end of a 2-lane SIMD sigmoid output interface. Q5.11 result pairs
// arrive with a valid only and no backpressure. They are stored in a pair
// FIFO and serialized onto one ready/valid stream, lane 0 first and then
// lane 1. Each sample carries its index in the original sample order.
// Sticky flags report dropped pairs and samples outside [0.0, 1.0].
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   clear              synchronous flush of FIFO, lane FSM, index and flags
//   y0_in, y1_in       lane 0 (even) and lane 1 (odd) results, signed Q5.11
//   valid_in           the input pair is valid this cycle
//   out_data, out_idx  serialized sample and its index tag
//   out_valid          out_data/out_idx valid; out_ready accepts
//   pair_count         number of pairs currently stored
//   overflow           sticky: a pair was dropped because the FIFO was full
//   range_err          sticky: an accepted sample was < 0 or > 1.0
module sigmoid_simd_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          y0_in,
  input  logic [DATA_W-1:0]          y1_in,
  input  logic                       valid_in,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     pair_count,
  output logic                       overflow,
  output logic                       range_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // 1.0 in Q(DATA_W-11).11 format, which is 0x0800 for a 16-bit sample
  localparam logic signed [DATA_W-1:0] ONE_Q = DATA_W'(1 << (DATA_W - 5));

  typedef enum logic {LANE0, LANE1} lane_e;

  logic [DATA_W-1:0] y0_mem_q  [DEPTH];
  logic [DATA_W-1:0] y1_mem_q  [DEPTH];
  logic [IDX_W-1:0]  idx_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] in_idx_q;
  logic             overflow_q, range_err_q;
  lane_e            lane_q, lane_d;

  logic hs, pop, full, push, drop;

  function automatic logic out_of_range(input logic [DATA_W-1:0] y);
    return y[DATA_W-1] || ($signed(y) > ONE_Q);
  endfunction

  assign out_valid  = (count_q != '0);
  assign pair_count = count_q;
  assign overflow   = overflow_q;
  assign range_err  = range_err_q;

  // When the FIFO is full, a pair may still enter if the head pair leaves
  // on the same edge.
  always_comb begin
    hs   = out_valid && out_ready;
    pop  = hs && (lane_q == LANE1);
    full = (count_q == CNT_W'(DEPTH));
    push = valid_in && (!full || pop);
    drop = valid_in && full && !pop;
  end

  // The lane FSM toggles on every handshake. Clear returns it to lane 0.
  always_comb begin
    lane_d = lane_q;
    if (clear) begin
      lane_d = LANE0;
    end else if (hs) begin
      lane_d = (lane_q == LANE0) ? LANE1 : LANE0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= LANE0;
    end else begin
      lane_q <= lane_d;
    end
  end

  // Outputs come only from stored state. They are forced to zero while the
  // FIFO is empty, so that reset and clear leave out_data and out_idx at 0.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    if (out_valid) begin
      if (lane_q == LANE1) begin
        out_data = y1_mem_q[rd_q];
        out_idx  = idx_mem_q[rd_q] + IDX_W'(1);
      end else begin
        out_data = y0_mem_q[rd_q];
        out_idx  = idx_mem_q[rd_q];
      end
    end
  end

  // The storage array has no reset. Entries are read only after a push.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      y0_mem_q[wr_q]  <= y0_in;
      y1_mem_q[wr_q]  <= y1_in;
      idx_mem_q[wr_q] <= in_idx_q;
    end
  end

  // Pointers, occupancy, index counter and sticky flags. The index counter
  // also advances on dropped pairs, so a drop appears downstream as an index gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      in_idx_q    <= '0;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else if (clear) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      in_idx_q    <= '0;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_q <= wr_q + PTR_W'(1);
        if (out_of_range(y0_in) || out_of_range(y1_in)) begin
          range_err_q <= 1'b1;
        end
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (valid_in) begin
        in_idx_q <= in_idx_q + IDX_W'(2);
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_simd_collector.sv
// tb_sigmoid_simd_collector
// Directed bench for sigmoid_simd_collector. The reference model holds the
// stream as a queue of individual output samples. An input pair appends two
// tagged samples, and a handshake removes the front sample. The pair count
// is the number of pairs with at least one sample still queued. Literal
// expectations in each scenario pin the model.
module tb_sigmoid_simd_collector;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] y0_in = '0;
  logic [DATA_W-1:0] y1_in = '0;
  logic              valid_in = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic [$clog2(DEPTH):0] pair_count;
  logic              overflow;
  logic              range_err;

  int checks = 0;
  int failures = 0;

  sigmoid_simd_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .y0_in(y0_in), .y1_in(y1_in), .valid_in(valid_in),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .pair_count(pair_count),
    .overflow(overflow), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of serialized samples.
  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  idx;
    logic        lane1;
  } samp_t;

  samp_t mq[$];
  samp_t mS;
  int    mInIdx = 0;
  bit    mOvf = 0, mRerr = 0;
  int    mPairs;
  bit    mHs, mPairPop;

  function automatic bit badSample(input logic [15:0] y);
    return (int'($signed(y)) < 0) || (int'($signed(y)) > 2048);
  endfunction

  task automatic modelReset();
    mq.delete();
    mInIdx = 0;
    mOvf = 0;
    mRerr = 0;
  endtask

  always @(negedge rst_n) modelReset();

  // Advance the model at each rising edge. Compare 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n || clear) begin
      modelReset();
    end else begin
      mPairs   = (mq.size() + 1) / 2;
      mHs      = (mq.size() > 0) && out_ready;
      mPairPop = mHs && mq[0].lane1;
      if (mHs) void'(mq.pop_front());
      if (valid_in) begin
        if (mPairs < DEPTH || mPairPop) begin
          mS.d = y0_in; mS.idx = 8'(mInIdx);     mS.lane1 = 1'b0; mq.push_back(mS);
          mS.d = y1_in; mS.idx = 8'(mInIdx + 1); mS.lane1 = 1'b1; mq.push_back(mS);
          if (badSample(y0_in) || badSample(y1_in)) mRerr = 1;
        end else begin
          mOvf = 1;
        end
        mInIdx = (mInIdx + 2) % 256;
      end
    end
    #1;
    checkOutput("model out_valid", out_valid, mq.size() > 0);
    checkOutput("model pair_count", pair_count, (mq.size() + 1) / 2);
    checkOutput("model overflow", overflow, mOvf);
    checkOutput("model range_err", range_err, mRerr);
    if (mq.size() > 0) begin
      checkOutput("model out_data", out_data, mq[0].d);
      checkOutput("model out_idx", out_idx, mq[0].idx);
    end
  end

  task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [15:0] b,
                               input bit rdy, input bit clr);
    @(negedge clk);
    valid_in = v; y0_in = a; y1_in = b; out_ready = rdy; clear = clr;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 0; y0_in = 0; y1_in = 0; out_ready = 0; clear = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] expData[$];
  logic [7:0]  expIdx[$];

  // Called at a falling edge. Accepts one sample per cycle and checks it
  // against the expectation queues.
  task automatic drainCheck(input string tag, input int n);
    out_ready = 1'b1;
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " valid"}, out_valid, 1);
      checkOutput({tag, " idx"}, out_idx, expIdx.pop_front());
      checkOutput({tag, " data"}, out_data, expData.pop_front());
      @(negedge clk);
    end
  endtask

  initial begin
    // Single pair
    resetDut();
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset pair_count", pair_count, 0);
    checkOutput("reset out_data", out_data, 0);
    applyStimulus(1, 16'h0400, 16'h07FF, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("single lane0 data", out_data, 16'h0400);
    checkOutput("single lane0 idx", out_idx, 0);
    checkOutput("single count", pair_count, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("single lane1 data", out_data, 16'h07FF);
    checkOutput("single lane1 idx", out_idx, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("single empty valid", out_valid, 0);
    checkOutput("single empty count", pair_count, 0);
    checkOutput("single flags", {overflow, range_err}, 0);

    // Backpressure
    resetDut();
    for (int k = 0; k < 3; k++) applyStimulus(1, 16'(256 * (k + 1)), 16'(256 * (k + 1) + 1), 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bp count", pair_count, 3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("bp hold data", out_data, 16'h0100);
      checkOutput("bp hold idx", out_idx, 0);
    end
    for (int i = 0; i < 6; i++) begin
      expData.push_back(16'(256 * (i / 2 + 1) + i % 2));
      expIdx.push_back(8'(i));
    end
    drainCheck("bp drain", 6);
    checkOutput("bp empty count", pair_count, 0);

    // Overflow
    resetDut();
    for (int k = 0; k < 10; k++) applyStimulus(1, 16'(2 * k), 16'(2 * k + 1), 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ovf count", pair_count, 8);
    checkOutput("ovf flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      expData.push_back(16'(i));
      expIdx.push_back(8'(i));
    end
    drainCheck("ovf drain", 16);
    applyStimulus(1, 16'h0055, 16'h0066, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("ovf gap idx", out_idx, 20);
    checkOutput("ovf gap data", out_data, 16'h0055);

    // Full with a push and a pop on the same edge
    resetDut();
    for (int k = 0; k < 8; k++) applyStimulus(1, 16'(2 * k), 16'(2 * k + 1), 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("full count", pair_count, 8);
    applyStimulus(1, 16'h0123, 16'h0456, 1, 0);
    checkOutput("full lane1 idx", out_idx, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("full pushpop count", pair_count, 8);
    checkOutput("full pushpop ovf", overflow, 0);
    for (int i = 2; i < 18; i++) begin
      expData.push_back(i == 16 ? 16'h0123 : (i == 17 ? 16'h0456 : 16'(i)));
      expIdx.push_back(8'(i));
    end
    drainCheck("full drain", 16);
    checkOutput("full empty count", pair_count, 0);

    // Range check and clear
    resetDut();
    applyStimulus(1, 16'h0000, 16'h0800, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("range boundary", range_err, 0);
    applyStimulus(1, 16'hFFFF, 16'h0801, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("range err", range_err, 1);
    checkOutput("range count", pair_count, 2);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clear range", range_err, 0);
    checkOutput("clear count", pair_count, 0);
    checkOutput("clear valid", out_valid, 0);
    applyStimulus(1, 16'h0200, 16'h0300, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clear idx restart", out_idx, 0);
    checkOutput("clear data", out_data, 16'h0200);

    // Asynchronous reset while lane 1 is pending
    resetDut();
    applyStimulus(1, 16'h0111, 16'h0222, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("async lane1 idx", out_idx, 1);
    checkOutput("async lane1 data", out_data, 16'h0222);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async valid", out_valid, 0);
    checkOutput("async count", pair_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("async post count", pair_count, 0);
    checkOutput("async post flags", {overflow, range_err}, 0);
    applyStimulus(1, 16'h0333, 16'h0444, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("async restart idx", out_idx, 0);
    checkOutput("async restart data", out_data, 16'h0333);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
